// File: rtl/mtx_stream_loader.sv
// mtx_stream_loader
// Double-buffered N x N complex matrix assembler. Cells arrive one at a time
// under valid/ready handshaking and are collected in a shadow bank. Once every
// real and imaginary cell has been seen, the shadow bank is copied to the
// active bank in a single edge, unless the consumer is holding it frozen.
module mtx_stream_loader #(
    parameter  int CELL_W   = 19,
    parameter  int DIM_LOG2 = 1,
    localparam int N        = 2 ** DIM_LOG2,
    localparam int NCELL    = 2 * N * N,
    localparam int CNT_W    = 2 * DIM_LOG2 + 2,
    localparam int IDX_W    = 2 * DIM_LOG2 + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CELL_W-1:0]         in_cell,
    input  logic                      in_imag,
    input  logic [DIM_LOG2-1:0]       in_row,
    input  logic [DIM_LOG2-1:0]       in_col,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      new_mtx,
    input  logic                      hold,
    output logic [NCELL*CELL_W-1:0]   matrix_flat,
    output logic                      mtx_valid,
    output logic                      done,
    output logic                      dup_err,
    output logic [CNT_W-1:0]          cell_count
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t            state;
    logic              armed;
    logic [NCELL-1:0]  mask;
    logic [CELL_W-1:0] shadow [NCELL];

    // {imag,row,col} concatenated is exactly imag*N*N + row*N + col
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic [NCELL-1:0]  mask_base;
    logic [NCELL-1:0]  mask_nxt;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              hit;

    assign idx      = {in_imag, in_row, in_col};
    // Ready depends only on registered state so it never loops back through in_valid;
    // armed keeps it low until the first edge after reset release.
    assign in_ready = armed && (state != S_FULL);
    assign accept   = in_valid && in_ready;

    // Next mask/count: a concurrent new_mtx clears first, then the accepted cell is recorded
    always_comb begin
        mask_base = new_mtx ? '0 : mask;
        cnt_base  = new_mtx ? '0 : cell_count;
        hit       = mask_base[idx];
        mask_nxt  = mask_base;
        if (accept) begin
            mask_nxt[idx] = 1'b1;
        end
        cnt_nxt = cnt_base + {{(CNT_W-1){1'b0}}, accept & ~hit};
    end

    // Ready qualifier: goes high on the first edge after reset is released
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Load/commit FSM with shadow and active banks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_EMPTY;
            mask        <= '0;
            cell_count  <= '0;
            matrix_flat <= '0;
            mtx_valid   <= 1'b0;
            done        <= 1'b0;
            dup_err     <= 1'b0;
            for (int k = 0; k < NCELL; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            done    <= 1'b0;
            dup_err <= 1'b0;
            case (state)
                S_FULL: begin
                    if (new_mtx) begin
                        // Discard the completed but uncommitted shadow
                        mask       <= '0;
                        cell_count <= '0;
                        state      <= S_EMPTY;
                    end else if (!hold) begin
                        for (int k = 0; k < NCELL; k++) begin
                            matrix_flat[k*CELL_W +: CELL_W] <= shadow[k];
                        end
                        mtx_valid  <= 1'b1;
                        done       <= 1'b1;
                        mask       <= '0;
                        cell_count <= '0;
                        state      <= S_EMPTY;
                    end
                end
                default: begin
                    mask       <= mask_nxt;
                    cell_count <= cnt_nxt;
                    dup_err    <= accept && hit;
                    if (accept) begin
                        shadow[idx] <= in_cell;
                        state       <= (&mask_nxt) ? S_FULL : S_LOADING;
                    end else if (new_mtx) begin
                        state <= S_EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtx_stream_loader.sv
// tb_mtx_stream_loader
// Two loaders (2x2 and 4x4) are driven with directed and random cell streams.
// A cycle-level reference model built from the cell/mask rules predicts every
// output, and directed scenarios add explicit end-of-load checks.
module tb_mtx_stream_loader;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // Instance A: 2x2
    logic [18:0]  a_cell  = '0;
    logic         a_imag  = 1'b0;
    logic [0:0]   a_row   = '0;
    logic [0:0]   a_col   = '0;
    logic         a_valid = 1'b0;
    logic         a_new   = 1'b0;
    logic         a_hold  = 1'b0;
    logic         a_rdy, a_mv, a_dn, a_de;
    logic [3:0]   a_cc;
    logic [151:0] a_mf;

    // Instance B: 4x4
    logic [18:0]  b_cell  = '0;
    logic         b_imag  = 1'b0;
    logic [1:0]   b_row   = '0;
    logic [1:0]   b_col   = '0;
    logic         b_valid = 1'b0;
    logic         b_new   = 1'b0;
    logic         b_hold  = 1'b0;
    logic         b_rdy, b_mv, b_dn, b_de;
    logic [5:0]   b_cc;
    logic [607:0] b_mf;

    int n_checks = 0;
    int n_errors = 0;
    int nd_a = 0, nd_b = 0, ndup_a = 0, nrl_a = 0;

    // Reference model state
    bit          m_full  [2];
    bit          m_mask  [2][32];
    logic [18:0] m_sh    [2][32];
    logic [18:0] m_act   [2][32];
    bit          m_valid [2];
    bit          m_done  [2];
    bit          m_dup   [2];
    bit          m_armed [2];
    int          m_cnt   [2];

    mtx_stream_loader #(.CELL_W(19), .DIM_LOG2(1)) u_a (
        .clk(clk), .reset(reset), .in_cell(a_cell), .in_imag(a_imag), .in_row(a_row),
        .in_col(a_col), .in_valid(a_valid), .in_ready(a_rdy), .new_mtx(a_new), .hold(a_hold),
        .matrix_flat(a_mf), .mtx_valid(a_mv), .done(a_dn), .dup_err(a_de), .cell_count(a_cc)
    );

    mtx_stream_loader #(.CELL_W(19), .DIM_LOG2(2)) u_b (
        .clk(clk), .reset(reset), .in_cell(b_cell), .in_imag(b_imag), .in_row(b_row),
        .in_col(b_col), .in_valid(b_valid), .in_ready(b_rdy), .new_mtx(b_new), .hold(b_hold),
        .matrix_flat(b_mf), .mtx_valid(b_mv), .done(b_dn), .dup_err(b_de), .cell_count(b_cc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [607:0] got, input logic [607:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [607:0] pack_act(input int i);
        logic [607:0] r;
        int nc;
        r  = '0;
        nc = (i == 0) ? 8 : 32;
        for (int k = 0; k < nc; k++) r[k*19 +: 19] = m_act[i][k];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_valid[i] = 0; m_done[i] = 0; m_dup[i] = 0;
            m_armed[i] = 0; m_cnt[i] = 0;
            for (int k = 0; k < 32; k++) begin
                m_mask[i][k] = 0; m_sh[i][k] = '0; m_act[i][k] = '0;
            end
        end
    endtask

    // Reference model: one step per rising edge, reset acts immediately
    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_clear();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    int nc, n, idx;
                    bit v, nm, hd, rdy, acc;
                    logic [18:0] val;
                    nc = (i == 0) ? 8 : 32;
                    n  = (i == 0) ? 2 : 4;
                    if (i == 0) begin
                        v = a_valid; nm = a_new; hd = a_hold; val = a_cell;
                        idx = int'(a_imag) * n * n + int'(a_row) * n + int'(a_col);
                    end else begin
                        v = b_valid; nm = b_new; hd = b_hold; val = b_cell;
                        idx = int'(b_imag) * n * n + int'(b_row) * n + int'(b_col);
                    end
                    rdy = m_armed[i] && !m_full[i];
                    acc = v && rdy;
                    m_armed[i] = 1;
                    m_done[i]  = 0;
                    m_dup[i]   = 0;
                    if (m_full[i]) begin
                        if (nm || !hd) begin
                            if (!nm) begin
                                for (int k = 0; k < nc; k++) m_act[i][k] = m_sh[i][k];
                                m_valid[i] = 1;
                                m_done[i]  = 1;
                            end
                            for (int k = 0; k < 32; k++) m_mask[i][k] = 0;
                            m_cnt[i]  = 0;
                            m_full[i] = 0;
                        end
                    end else begin
                        if (nm) begin
                            for (int k = 0; k < 32; k++) m_mask[i][k] = 0;
                            m_cnt[i] = 0;
                        end
                        if (acc) begin
                            if (m_mask[i][idx]) m_dup[i] = 1;
                            else m_cnt[i]++;
                            m_mask[i][idx] = 1;
                            m_sh[i][idx]   = val;
                            if (m_cnt[i] == nc) m_full[i] = 1;
                        end
                    end
                end
            end
        end
    end

    // Every falling edge: compare all outputs of both instances with the model
    initial begin
        forever begin
            @(negedge clk);
            check_val("a_ready", a_rdy, m_armed[0] && !m_full[0]);
            check_val("a_mtx_valid", a_mv, m_valid[0]);
            check_val("a_done", a_dn, m_done[0]);
            check_val("a_dup_err", a_de, m_dup[0]);
            check_val("a_cell_count", a_cc, m_cnt[0]);
            check_val("a_matrix", a_mf, pack_act(0));
            check_val("b_ready", b_rdy, m_armed[1] && !m_full[1]);
            check_val("b_mtx_valid", b_mv, m_valid[1]);
            check_val("b_done", b_dn, m_done[1]);
            check_val("b_dup_err", b_de, m_dup[1]);
            check_val("b_cell_count", b_cc, m_cnt[1]);
            check_val("b_matrix", b_mf, pack_act(1));
            if (a_dn === 1'b1) nd_a++;
            if (b_dn === 1'b1) nd_b++;
            if (a_de === 1'b1) ndup_a++;
            if (reset && a_rdy === 1'b0) nrl_a++;
        end
    end

    task automatic drv(input int i, input bit v, input int idx, input int val,
                       input bit nm, input bit hd);
        @(negedge clk);
        if (i == 0) begin
            a_valid = v; a_cell = 19'(val); a_new = nm; a_hold = hd;
            a_col = 1'(idx % 2); a_row = 1'((idx / 2) % 2); a_imag = 1'(idx / 4);
        end else begin
            b_valid = v; b_cell = 19'(val); b_new = nm; b_hold = hd;
            b_col = 2'(idx % 4); b_row = 2'((idx / 4) % 4); b_imag = 1'(idx / 16);
        end
    endtask

    task automatic idle(input int i, input int n, input bit hd);
        for (int c = 0; c < n; c++) drv(i, 0, 0, 0, 0, hd);
    endtask

    initial begin
        int d0, r0, u0;
        int perm [32];
        int vals [32];

        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(0, 2, 0);
        #1;

        // 1: in-order 2x2 load with valid held high
        d0 = nd_a; r0 = nrl_a;
        for (int k = 0; k < 8; k++) drv(0, 1, k, k + 1, 0, 0);
        idle(0, 4, 0);
        #1;
        check_val("t1_done_count", nd_a - d0, 1);
        check_val("t1_ready_low_cycles", nrl_a - r0, 1);
        check_val("t1_mtx_valid", a_mv, 1);
        for (int k = 0; k < 8; k++) check_val($sformatf("t1_cell%0d", k), a_mf[k*19 +: 19], k + 1);

        // 3: completed load frozen by hold for 10 cycles
        for (int k = 0; k < 8; k++) drv(0, 1, k, 100 + k, 0, 1);
        for (int c = 0; c < 10; c++) begin
            drv(0, 0, 0, 0, 0, 1);
            #1;
            check_val("t3_ready_in_hold", a_rdy, 0);
            check_val("t3_cell0_in_hold", a_mf[18:0], 1);
            check_val("t3_cell7_in_hold", a_mf[7*19 +: 19], 8);
        end
        d0 = nd_a;
        idle(0, 4, 0);
        #1;
        check_val("t3_done_count", nd_a - d0, 1);
        for (int k = 0; k < 8; k++) check_val($sformatf("t3_cell%0d", k), a_mf[k*19 +: 19], 100 + k);

        // 4: duplicate write to idx 3, last write wins
        d0 = nd_a; u0 = ndup_a;
        drv(0, 1, 3, 5, 0, 0);
        drv(0, 1, 3, 9, 0, 0);
        drv(0, 1, 0, 50, 0, 0);
        #1;
        check_val("t4_count_after_repeat", a_cc, 1);
        for (int k = 1; k < 8; k++) if (k != 3) drv(0, 1, k, 50 + k, 0, 0);
        idle(0, 4, 0);
        #1;
        check_val("t4_dup_count", ndup_a - u0, 1);
        check_val("t4_done_count", nd_a - d0, 1);
        check_val("t4_cell3", a_mf[3*19 +: 19], 9);
        check_val("t4_cell0", a_mf[18:0], 50);

        // 5: new_mtx with a concurrent cell restarts the load
        d0 = nd_a;
        drv(0, 1, 0, 60, 0, 0);
        drv(0, 1, 1, 61, 0, 0);
        drv(0, 1, 3, 63, 0, 0);
        drv(0, 1, 4, 64, 0, 0);
        drv(0, 1, 5, 65, 0, 0);
        drv(0, 1, 2, 7, 1, 0);
        drv(0, 1, 0, 80, 0, 0);
        #1;
        check_val("t5_count_after_restart", a_cc, 1);
        drv(0, 1, 1, 81, 0, 0);
        drv(0, 1, 3, 83, 0, 0);
        drv(0, 1, 4, 84, 0, 0);
        drv(0, 1, 5, 85, 0, 0);
        drv(0, 1, 6, 86, 0, 0);
        idle(0, 3, 0);
        #1;
        check_val("t5_no_early_done", nd_a - d0, 0);
        drv(0, 1, 7, 87, 0, 0);
        idle(0, 4, 0);
        #1;
        check_val("t5_done_count", nd_a - d0, 1);
        check_val("t5_cell2", a_mf[2*19 +: 19], 7);
        for (int k = 0; k < 8; k++) if (k != 2)
            check_val($sformatf("t5_cell%0d", k), a_mf[k*19 +: 19], 80 + k);

        // 2: 4x4 loads in random order with random valid gaps
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 32; k++) begin
                perm[k] = k;
                vals[k] = int'($urandom & 32'h7FFFF);
            end
            for (int k = 31; k > 0; k--) begin
                int j, t;
                j = int'($urandom_range(k, 0));
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
            d0 = nd_b;
            for (int k = 0; k < 32; k++) begin
                idle(1, int'($urandom_range(2, 0)), 0);
                drv(1, 1, perm[k], vals[perm[k]], 0, 0);
                if (k == 30) begin
                    #1;
                    check_val("t2_no_early_done", nd_b - d0, 0);
                end
            end
            idle(1, 4, 0);
            #1;
            check_val("t2_done_count", nd_b - d0, 1);
            check_val("t2_cell_count_after", b_cc, 0);
            for (int k = 0; k < 32; k++)
                check_val($sformatf("t2_cell%0d", k), b_mf[k*19 +: 19], vals[k]);
        end

        // Random soak on the 2x2 instance (checked each cycle against the model)
        for (int c = 0; c < 400; c++) begin
            drv(0, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
                int'($urandom & 32'h7FFFF), $urandom_range(29, 0) == 0,
                $urandom_range(3, 0) == 0);
        end
        drv(0, 0, 0, 0, 1, 0);
        idle(0, 2, 0);

        // 6: reset during a held FULL, then a fresh load
        for (int k = 0; k < 8; k++) drv(0, 1, k, 150 + k, 0, 1);
        idle(0, 3, 1);
        #2;
        reset = 1'b0;
        #1;
        check_val("t6_rst_ready", a_rdy, 0);
        check_val("t6_rst_mtx_valid", a_mv, 0);
        check_val("t6_rst_done", a_dn, 0);
        check_val("t6_rst_dup_err", a_de, 0);
        check_val("t6_rst_cell_count", a_cc, 0);
        check_val("t6_rst_matrix", a_mf, 0);
        a_hold = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_val("t6_ready_after_release", a_rdy, 1);
        d0 = nd_a;
        for (int k = 0; k < 8; k++) drv(0, 1, k, 200 + k, 0, 0);
        idle(0, 4, 0);
        #1;
        check_val("t6_done_count", nd_a - d0, 1);
        check_val("t6_mtx_valid", a_mv, 1);
        for (int k = 0; k < 8; k++) check_val($sformatf("t6_cell%0d", k), a_mf[k*19 +: 19], 200 + k);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
